// File: rtl/dram_sim_pkg.sv
// Shared types and sizing helpers for the DRAM-model AXI path.
package dram_sim_pkg;

  localparam int unsigned PerfCntW = 32;
  localparam int unsigned AxiLenW  = 8;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefDataW = 512;
  localparam int unsigned DefIdW   = 5;
  localparam int unsigned DefUserW = 5;

  // One extra bit beyond the budget so an over-budget sum is still representable.
  function automatic int unsigned cnt_width(input int unsigned max_beats);
    return $clog2(max_beats + 1) + 1;
  endfunction

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefAddrW-1:0] addr;
    logic [AxiLenW-1:0]  len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [5:0]          atop;
    logic [DefUserW-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [DefDataW-1:0]   data;
    logic [DefDataW/8-1:0] strb;
    logic                  last;
    logic [DefUserW-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [1:0]          resp;
    logic [DefUserW-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefAddrW-1:0] addr;
    logic [AxiLenW-1:0]  len;
    logic [2:0]          size;
    logic [1:0]          burst;
    logic                lock;
    logic [3:0]          cache;
    logic [2:0]          prot;
    logic [3:0]          qos;
    logic [3:0]          region;
    logic [DefUserW-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [DefIdW-1:0]   id;
    logic [DefDataW-1:0] data;
    logic [1:0]          resp;
    logic                last;
    logic [DefUserW-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_resp_t;

endpackage

// File: rtl/axi_dram_rd_credit_cnt.sv
// Outstanding read-beat counter and AR admission decision.
module axi_dram_rd_credit_cnt
  import dram_sim_pkg::*;
#(
  parameter int unsigned MaxOutstandingBeats = 64,
  parameter int unsigned CntW                = cnt_width(MaxOutstandingBeats)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [AxiLenW-1:0] ar_len_i,
  input  logic               ar_hs_i,
  input  logic               r_hs_i,
  output logic [CntW-1:0]    inflight_o,
  output logic               admit_o
);

  localparam int unsigned SumW = CntW + AxiLenW + 1;

  logic [CntW-1:0] inflight_q, inflight_d;
  logic [SumW-1:0] need, next;

  always_comb begin
    need    = SumW'(inflight_q) + SumW'(ar_len_i) + SumW'(1);
    // An empty pipe admits anything, so bursts larger than the budget still make progress.
    admit_o = (need <= SumW'(MaxOutstandingBeats)) || (inflight_q == '0);
    next    = SumW'(inflight_q);
    if (ar_hs_i) next = need;
    if (r_hs_i && next != '0) next = next - SumW'(1);
    inflight_d = CntW'(next);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  assign inflight_o = inflight_q;

`ifndef SYNTHESIS
  underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(r_hs_i && !ar_hs_i && inflight_q == '0));
`endif

endmodule

// File: rtl/axi_dram_rd_regulator.sv
// AR admission gate bounding outstanding read beats ahead of axi_dram_sim.
// DRAM_RD_REG_PERF_EN enables the rd_txns/rd_beats/stall_cycles counters.
module axi_dram_rd_regulator
  import dram_sim_pkg::*;
#(
  parameter int unsigned AxiAddrWidth        = 32,
  parameter int unsigned AxiDataWidth        = 512,
  parameter int unsigned AxiIdWidth          = 5,
  parameter int unsigned AxiUserWidth        = 5,
  parameter int unsigned MaxOutstandingBeats = 64,
  parameter type         axi_req_t           = dram_sim_pkg::axi_req_t,
  parameter type         axi_resp_t          = dram_sim_pkg::axi_resp_t,
  localparam int unsigned CntW               = cnt_width(MaxOutstandingBeats)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  axi_req_t            slv_req_i,
  output axi_resp_t           slv_resp_o,
  output axi_req_t            mst_req_o,
  input  axi_resp_t           mst_resp_i,
  output logic [CntW-1:0]     inflight_o,
  output logic                ar_stall_o,
  output logic [PerfCntW-1:0] rd_txns_o,
  output logic [PerfCntW-1:0] rd_beats_o,
  output logic [PerfCntW-1:0] stall_cycles_o
);

  if ($bits(slv_req_i.ar.addr) != AxiAddrWidth || $bits(slv_resp_o.r.data) != AxiDataWidth ||
      $bits(slv_req_i.ar.id) != AxiIdWidth || $bits(slv_req_i.ar.user) != AxiUserWidth ||
      MaxOutstandingBeats < 1) begin : gen_cfg_err
    $error("axi_dram_rd_regulator: struct widths or budget inconsistent with parameters");
  end

  logic admit, ar_hs, r_hs;

  axi_dram_rd_credit_cnt #(
    .MaxOutstandingBeats(MaxOutstandingBeats),
    .CntW               (CntW)
  ) u_credit_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ar_len_i  (slv_req_i.ar.len),
    .ar_hs_i   (ar_hs),
    .r_hs_i    (r_hs),
    .inflight_o(inflight_o),
    .admit_o   (admit)
  );

  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & admit;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & admit;
  end

  assign ar_hs      = slv_req_i.ar_valid & admit & mst_resp_i.ar_ready;
  assign r_hs       = mst_resp_i.r_valid & slv_req_i.r_ready;
  assign ar_stall_o = slv_req_i.ar_valid & ~admit;

`ifdef DRAM_RD_REG_PERF_EN
  logic [PerfCntW-1:0] rd_txns_q, rd_beats_q, stall_cycles_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_txns_q      <= '0;
      rd_beats_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      // Saturate rather than wrap so long runs never report a small count.
      if (ar_hs && rd_txns_q != '1)            rd_txns_q      <= rd_txns_q + PerfCntW'(1);
      if (r_hs && rd_beats_q != '1)            rd_beats_q     <= rd_beats_q + PerfCntW'(1);
      if (ar_stall_o && stall_cycles_q != '1)  stall_cycles_q <= stall_cycles_q + PerfCntW'(1);
    end
  end

  assign rd_txns_o      = rd_txns_q;
  assign rd_beats_o     = rd_beats_q;
  assign stall_cycles_o = stall_cycles_q;
`else
  assign rd_txns_o      = '0;
  assign rd_beats_o     = '0;
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_axi_dram_rd_regulator.sv
// Randomized self-checking bench for axi_dram_rd_regulator against a beat-budget model.
module tb_axi_dram_rd_regulator;
  import dram_sim_pkg::*;

  localparam int Budget = 64;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  axi_req_t    slv_req, mst_req;
  axi_resp_t   slv_resp, mst_resp;
  logic [7:0]  inflight;
  logic        ar_stall;
  logic [31:0] rd_txns, rd_beats, stall_cycles;

  int     vectors = 0, miscompares = 0;
  int     m_inflight = 0;
  longint m_txns = 0, m_beats = 0, m_stalls = 0;

  always #5 clk_i = ~clk_i;

  axi_dram_rd_regulator #(
    .MaxOutstandingBeats(Budget)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .slv_req_i     (slv_req),
    .slv_resp_o    (slv_resp),
    .mst_req_o     (mst_req),
    .mst_resp_i    (mst_resp),
    .inflight_o    (inflight),
    .ar_stall_o    (ar_stall),
    .rd_txns_o     (rd_txns),
    .rd_beats_o    (rd_beats),
    .stall_cycles_o(stall_cycles)
  );

  // Budget rule: a burst fits if its beats stay within budget, or if nothing is outstanding.
  function automatic bit model_admit();
    return (m_inflight + int'(slv_req.ar.len) + 1 <= Budget) || (m_inflight == 0);
  endfunction

  function automatic logic [31:0] exp_perf(input longint v);
`ifdef DRAM_RD_REG_PERF_EN
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  // Advance one clock; the model consumes the inputs present at this edge.
  task automatic tick();
    bit arh, rh, st;
    int len;
    @(negedge clk_i);
    len = int'(slv_req.ar.len);
    arh = slv_req.ar_valid && mst_resp.ar_ready && model_admit();
    rh  = mst_resp.r_valid && slv_req.r_ready;
    st  = slv_req.ar_valid && !model_admit();
    @(posedge clk_i);
    #1;
    if (rst_i) begin
      m_inflight = 0; m_txns = 0; m_beats = 0; m_stalls = 0;
    end else begin
      m_inflight = m_inflight + (arh ? len + 1 : 0) - (rh ? 1 : 0);
      if (m_inflight < 0) m_inflight = 0;
      m_txns += longint'(arh); m_beats += longint'(rh); m_stalls += longint'(st);
    end
  endtask

  task automatic idle_inputs();
    slv_req  = '0;
    mst_resp = '0;
    slv_req.r_ready     = 1'b1;
    mst_resp.ar_ready   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) tick();
    vectors += 5;
    if (inflight !== 8'd0) begin
      miscompares++; $display("FAIL reset_inflight: got %0d need 0", inflight);
    end
    if (ar_stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b need 0", ar_stall);
    end
    if (rd_txns !== 32'd0) begin
      miscompares++; $display("FAIL reset_txns: got %0d need 0", rd_txns);
    end
    if (rd_beats !== 32'd0) begin
      miscompares++; $display("FAIL reset_beats: got %0d need 0", rd_beats);
    end
    if (stall_cycles !== 32'd0) begin
      miscompares++; $display("FAIL reset_stalls: got %0d need 0", stall_cycles);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [$bits(axi_req_t)-1:0]  rq;
    logic [$bits(axi_resp_t)-1:0] rs;
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int b = 0; b < $bits(rq); b++) rq[b] = 1'($urandom_range(0, 1));
      for (int b = 0; b < $bits(rs); b++) rs[b] = 1'($urandom_range(0, 1));
      slv_req  = axi_req_t'(rq);
      mst_resp = axi_resp_t'(rs);
      slv_req.ar_valid = 1'b0;
      #1;
      vectors += 2;
      if (mst_req !== slv_req) begin
        miscompares++;
        $display("FAIL passthrough_req: got %h need %h (low 64 bits, %0d bits differ)",
                 mst_req[63:0], slv_req[63:0], $countones(mst_req ^ slv_req));
      end
      if (slv_resp !== mst_resp) begin
        miscompares++;
        $display("FAIL passthrough_resp: got %h need %h (low 64 bits, %0d bits differ)",
                 slv_resp[63:0], mst_resp[63:0], $countones(slv_resp ^ mst_resp));
      end
      mst_resp.r_valid = 1'b0;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fill();
    int accepted = 0;
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (slv_req.ar_valid && slv_resp.ar_ready) accepted++;
      tick();
    end
    #1;
    vectors += 3;
    if (accepted != Budget) begin
      miscompares++; $display("FAIL fill_accepted: got %0d need %0d", accepted, Budget);
    end
    if (ar_stall !== 1'b1) begin
      miscompares++; $display("FAIL fill_stall: got %b need 1", ar_stall);
    end
    if (inflight !== 8'(Budget)) begin
      miscompares++; $display("FAIL fill_inflight: got %0d need %0d", inflight, Budget);
    end
    idle_inputs();
  endtask

  task automatic test_drain_admit();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd59;
    tick();
    vectors++;
    if (inflight !== 8'd60) begin
      miscompares++; $display("FAIL drain_start: got %0d need 60", inflight);
    end
    slv_req.ar.len   = 8'd7;
    mst_resp.r_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors += 2;
      if (ar_stall !== 1'b1) begin
        miscompares++; $display("FAIL drain_stall[%0d]: got %b need 1", c, ar_stall);
      end
      if (mst_req.ar_valid !== 1'b0) begin
        miscompares++; $display("FAIL drain_mst_valid[%0d]: got %b need 0", c, mst_req.ar_valid);
      end
      tick();
    end
    mst_resp.r_valid = 1'b0;
    #1;
    vectors += 3;
    if (inflight !== 8'd56) begin
      miscompares++; $display("FAIL drain_mid: got %0d need 56", inflight);
    end
    if (ar_stall !== 1'b0) begin
      miscompares++; $display("FAIL drain_admit_stall: got %b need 0", ar_stall);
    end
    if (slv_resp.ar_ready !== 1'b1) begin
      miscompares++; $display("FAIL drain_admit_ready: got %b need 1", slv_resp.ar_ready);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    vectors++;
    if (inflight !== 8'd64) begin
      miscompares++; $display("FAIL drain_end: got %0d need 64", inflight);
    end
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd9;
    tick();
    slv_req.ar.len   = 8'd3;
    mst_resp.r_valid = 1'b1;
    tick();
    vectors++;
    if (inflight !== 8'd13) begin
      miscompares++; $display("FAIL same_cycle: got %0d need 13", inflight);
    end
    idle_inputs();
  endtask

  task automatic test_oversize();
    int stalls = 0;
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd99;
    #1;
    vectors++;
    if (ar_stall !== 1'b0) begin
      miscompares++; $display("FAIL oversize_admit: got stall %b need 0", ar_stall);
    end
    tick();
    vectors++;
    if (inflight !== 8'd100) begin
      miscompares++; $display("FAIL oversize_inflight: got %0d need 100", inflight);
    end
    slv_req.ar.len   = 8'd0;
    mst_resp.r_valid = 1'b1;
    for (int c = 0; c < 200 && m_inflight > Budget - 1; c++) begin
      #1;
      vectors++;
      if (ar_stall !== 1'b1) begin
        miscompares++; $display("FAIL oversize_hold[%0d]: got %b need 1", c, ar_stall);
      end
      if (ar_stall) stalls++;
      tick();
    end
    mst_resp.r_valid = 1'b0;
    #1;
    vectors += 2;
    if (stalls != 37) begin
      miscompares++; $display("FAIL oversize_stall_count: got %0d need 37", stalls);
    end
    if (ar_stall !== 1'b0) begin
      miscompares++; $display("FAIL oversize_release: got %b need 0", ar_stall);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    vectors++;
    if (inflight !== 8'd64) begin
      miscompares++; $display("FAIL oversize_final: got %0d need 64", inflight);
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.len   = 8'd19;
    tick();
    slv_req.ar_valid = 1'b0;
    vectors++;
    if (inflight !== 8'd20) begin
      miscompares++; $display("FAIL rst_pre: got %0d need 20", inflight);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    vectors += 4;
    if (inflight !== 8'd0) begin
      miscompares++; $display("FAIL rst_inflight: got %0d need 0", inflight);
    end
    if (rd_txns !== 32'd0) begin
      miscompares++; $display("FAIL rst_txns: got %0d need 0", rd_txns);
    end
    if (rd_beats !== 32'd0) begin
      miscompares++; $display("FAIL rst_beats: got %0d need 0", rd_beats);
    end
    if (stall_cycles !== 32'd0) begin
      miscompares++; $display("FAIL rst_stalls: got %0d need 0", stall_cycles);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit adm, hs;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (!slv_req.ar_valid && $urandom_range(0, 2) != 0) begin
        slv_req.ar_valid = 1'b1;
        slv_req.ar.len   = 8'($urandom_range(0, 15));
      end
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      mst_resp.r_valid  = (m_inflight > 0) && ($urandom_range(0, 1) != 0);
      slv_req.r_ready   = ($urandom_range(0, 3) != 0);
      #1;
      adm = model_admit();
      hs  = slv_req.ar_valid && mst_resp.ar_ready && adm;
      vectors += 3;
      if (ar_stall !== (slv_req.ar_valid && !adm)) begin
        miscompares++; $display("FAIL rand_stall[%0d]: got %b need %b", c, ar_stall,
                                slv_req.ar_valid && !adm);
      end
      if (mst_req.ar_valid !== (slv_req.ar_valid && adm)) begin
        miscompares++; $display("FAIL rand_mst_valid[%0d]: got %b need %b", c, mst_req.ar_valid,
                                slv_req.ar_valid && adm);
      end
      if (slv_resp.ar_ready !== (mst_resp.ar_ready && adm)) begin
        miscompares++; $display("FAIL rand_slv_ready[%0d]: got %b need %b", c, slv_resp.ar_ready,
                                mst_resp.ar_ready && adm);
      end
      tick();
      if (hs) slv_req.ar_valid = 1'b0;
      vectors++;
      if (inflight !== 8'(m_inflight)) begin
        miscompares++; $display("FAIL rand_inflight[%0d]: got %0d need %0d", c, inflight,
                                m_inflight);
      end
    end
    vectors += 3;
    if (rd_txns !== exp_perf(m_txns)) begin
      miscompares++; $display("FAIL rand_txns: got %0d need %0d", rd_txns, exp_perf(m_txns));
    end
    if (rd_beats !== exp_perf(m_beats)) begin
      miscompares++; $display("FAIL rand_beats: got %0d need %0d", rd_beats, exp_perf(m_beats));
    end
    if (stall_cycles !== exp_perf(m_stalls)) begin
      miscompares++; $display("FAIL rand_stalls: got %0d need %0d", stall_cycles,
                              exp_perf(m_stalls));
    end
    idle_inputs();
  endtask

  task automatic test_perf();
    int  obs_stalls = 0;
    bit  done = 1'b0;
    do_reset();
    slv_req.ar.len = 8'd0;
    for (int c = 0; c < 40000 && !done; c++) begin
      slv_req.ar_valid = (m_txns < 10000);
      mst_resp.r_valid = (m_inflight > 0) && ($urandom_range(0, 3) != 0);
      #1;
      if (ar_stall) obs_stalls++;
      tick();
      done = (m_txns == 10000) && (m_beats == 10000);
    end
    idle_inputs();
    vectors += 5;
    if (!done) begin
      miscompares++; $display("FAIL perf_timeout: got txns=%0d beats=%0d need 10000 each",
                              m_txns, m_beats);
    end
    if (longint'(obs_stalls) != m_stalls) begin
      miscompares++; $display("FAIL perf_stall_signal: got %0d cycles need %0d", obs_stalls,
                              m_stalls);
    end
    if (rd_txns !== exp_perf(64'd10000)) begin
      miscompares++; $display("FAIL perf_txns: got %0d need %0d", rd_txns, exp_perf(64'd10000));
    end
    if (rd_beats !== exp_perf(64'd10000)) begin
      miscompares++; $display("FAIL perf_beats: got %0d need %0d", rd_beats, exp_perf(64'd10000));
    end
    if (stall_cycles !== exp_perf(longint'(obs_stalls))) begin
      miscompares++; $display("FAIL perf_stalls: got %0d need %0d", stall_cycles,
                              exp_perf(longint'(obs_stalls)));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_passthrough();
    test_fill();
    test_drain_admit();
    test_same_cycle();
    test_oversize();
    test_reset_inflight();
    test_random();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
